pc_sequencer: RTL

- Owns the nRISC program counter. Each cycle it selects the next PC from: sequential increment, taken relative branch, or absolute jump.
- Holds the PC under pipeline stall, instruction-memory backpressure or halt.
- Sits between decode/control and the instruction-memory fetch port.
- Contains the +1 incrementer path as a sub-module and a small run-state FSM.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_sequencer_incr.sv | 13 +
 rtl/pc_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the nRISC program-counter sequencer:
// run-state encoding, next-PC source select, and default geometry.
package pc_seq_pkg;

  localparam int              PC_W_DEF      = 8;
  localparam logic [7:0]      RESET_VEC_DEF = 8'h00;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP
  } sel_e;

endpackage

// File: rtl/pc_sequencer_incr.sv
// Combinational W-bit +1 with carry-out; the carry marks the all-ones to
// zero rollover used for wrap detection.
module pc_incrementer #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/pc_sequencer.sv
// nRISC program counter: sequential / branch / jump next-PC selection with
// BOOT/RUN/HALT run-state FSM. Optional macro PC_WRAP_TRAP_EN turns a
// sequential rollover from all-ones into a halt trap instead of a wrap.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter int              BR_OFF_W  = 4,
  parameter int              CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_ready,
  input  logic                stall,
  input  logic                branch_en,
  input  logic                branch_cond,
  input  logic [BR_OFF_W-1:0] branch_off,
  input  logic                jump_en,
  input  logic [PC_W-1:0]     jump_addr,
  input  logic                halt,
  input  logic                resume,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     pc_plus1,
  output logic                fetch_valid,
  output logic                halted,
  output logic                wrap,
  output logic [CNT_W-1:0]    fetch_cnt
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              wrap_q, wrap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry;
  logic              advance;
  sel_e              sel;
  logic [PC_W-1:0]   off_ext;

  pc_incrementer #(.W(PC_W)) u_incr (
    .a    (pc_q),
    .sum  (pc_plus1),
    .carry(carry)
  );

  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign advance     = fetch_valid & imem_ready & ~stall & ~halt;
  assign off_ext     = {{(PC_W-BR_OFF_W){branch_off[BR_OFF_W-1]}}, branch_off};

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;

    sel = SEL_SEQ;
    if (jump_en)                     sel = SEL_JMP;
    else if (branch_en && branch_cond) sel = SEL_BR;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (resume && !halt) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (advance) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      unique case (sel)
        SEL_JMP: pc_d = jump_addr;
        SEL_BR:  pc_d = pc_plus1 + off_ext;
        default: begin
          pc_d = pc_plus1;
          if (carry) begin
            wrap_d = 1'b1;
`ifdef PC_WRAP_TRAP_EN
            // Trap: refuse the rollover and park in HALT at the all-ones PC.
            pc_d    = pc_q;
            state_d = HALT;
`endif
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign wrap      = wrap_q;
  assign fetch_cnt = cnt_q;

endmodule
